// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, runs the CPU for a fixed time, then dumps its registers
module prog_loader #(
    parameter  int ADDR_W     = 8,
    parameter  int NUM_REGS   = 8,
    parameter  int REG_W      = 16,
    parameter  int RUN_CYCLES = 16,
    localparam int IW         = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic [IW-1:0]     dbg_addr,
    input  logic [REG_W-1:0]  dbg_rdata,
    output logic              dump_valid,
    output logic [IW-1:0]     dump_idx,
    output logic [REG_W-1:0]  dump_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} state_t;
    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [IW:0]     LAST_IDX = (IW+1)'(NUM_REGS);
    localparam logic [15:0]     RUN_LAST = 16'(RUN_CYCLES - 1);

    state_t          state, state_nxt;
    logic [ADDR_W:0] len, cnt;
    logic [15:0]     run_cnt;
    logic [IW:0]     idx;
    logic            accept, len_ok, take, dump_rd;

    assign accept  = (state == IDLE || state == DONE) && start;
    assign len_ok  = !prog_len[0] && prog_len != '0 && prog_len <= DEPTH;
    assign take    = state == LOAD && s_valid;
    assign dump_rd = state == DUMP && idx < LAST_IDX;

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;

    // next state: DUMP runs one extra clock so DONE follows the last strobe
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = accept && len_ok ? LOAD : state;
            LOAD:       state_nxt = take && cnt == len - 1'b1 ? RUN : LOAD;
            RUN:        state_nxt = run_cnt == RUN_LAST ? DUMP : RUN;
            DUMP:       state_nxt = idx == LAST_IDX ? DONE : DUMP;
            default:    state_nxt = IDLE;
        endcase
    end

    // counters, err pulse and the registered dump strobe
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            len        <= '0;
            cnt        <= '0;
            run_cnt    <= '0;
            idx        <= '0;
            err        <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
        end else begin
            if (accept && len_ok) begin
                len <= prog_len;
                cnt <= '0;
            end else if (take) begin
                cnt <= cnt + 1'b1;
            end
            run_cnt    <= state == RUN ? run_cnt + 1'b1 : '0;
            idx        <= state == DUMP ? idx + 1'b1 : '0;
            err        <= accept && !len_ok;
            dump_valid <= dump_rd;
            if (dump_rd) begin
                dump_idx  <= dbg_addr;
                dump_data <= dbg_rdata;
            end
        end

    // state-decoded outputs
    always_comb begin
        s_ready   = state == LOAD;
        mem_we    = take;
        mem_addr  = state == LOAD ? cnt[ADDR_W-1:0] : '0;
        mem_wdata = state == LOAD ? s_data : '0;
        cpu_reset = state == IDLE || state == LOAD;
        cpu_run   = state == RUN;
        dbg_addr  = dump_rd ? idx[IW-1:0] : '0;
        busy      = state == LOAD || state == RUN || state == DUMP;
        done      = state == DONE;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the instruction-memory byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, meaning the number of CPU registers dumped.
REQ-003 The block SHALL have parameter REG_W, default 16, meaning the register width.
REQ-004 The block SHALL have parameter RUN_CYCLES, default 16, meaning the number of clocks the CPU is enabled after load (legal range 1 to 2**16-1).
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a load/run/dump session.
- prog_len  in  ADDR_W+1  program length in bytes, sampled when start is accepted.
- s_valid  in  1  input byte valid.
- s_data  in  8  input program byte.
- s_ready  out  1  byte accepted when s_valid and s_ready are both 1.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  instruction-memory byte address.
- mem_wdata  out  8  instruction-memory write byte.
- cpu_reset  out  1  active-high reset to the CPU.
- cpu_run  out  1  CPU PC and register-write enable.
- dbg_addr  out  clog2(NUM_REGS)  register-file debug read index.
- dbg_rdata  in  REG_W  combinational register-file read data.
- dump_valid  out  1  dump_idx/dump_data valid strobe.
- dump_idx  out  clog2(NUM_REGS)  index of the dumped register.
- dump_data  out  REG_W  dumped register value.
- busy  out  1  session in progress.
- done  out  1  session complete.
- err  out  1  one-cycle pulse on a rejected start.

Function
REQ-006 The block SHALL implement the FSM states IDLE, LOAD, RUN, DUMP and DONE.
REQ-007 In IDLE, when start=1 and prog_len is even, nonzero and ≤2**ADDR_W, the block SHALL latch prog_len, clear the byte counter and go to LOAD on the next edge.
REQ-008 In IDLE, when start=1 and prog_len is zero, odd or greater than 2**ADDR_W, the block SHALL pulse err for exactly 1 cycle and stay in IDLE, with no mem_we.
REQ-009 In LOAD, s_ready SHALL be 1 and mem_we SHALL equal s_valid&s_ready combinationally, with mem_addr equal to the byte counter and mem_wdata equal to s_data.
REQ-010 Each accepted byte SHALL increment the counter by 1; s_valid gaps SHALL stall the load without a write.
REQ-011 When the byte at counter prog_len-1 is accepted, the block SHALL enter RUN on the next edge and SHALL accept no further bytes.
REQ-012 s_ready SHALL be 0 in every state other than LOAD.
REQ-013 In RUN, cpu_reset SHALL be 0 and cpu_run SHALL be 1 for exactly RUN_CYCLES clocks, counted by an internal 16-bit counter; the block SHALL then enter DUMP.
REQ-014 cpu_reset SHALL be 1 in IDLE and LOAD, and 0 in RUN, DUMP and DONE, so that register contents are preserved.
REQ-015 cpu_run SHALL be 0 in every state other than RUN.
REQ-016 In DUMP, dbg_addr SHALL step 0 to NUM_REGS-1, one index per clock.
REQ-017 One clock after dbg_addr=i, dump_valid SHALL be 1, dump_idx SHALL be i and dump_data SHALL be the registered dbg_rdata, giving exactly NUM_REGS consecutive strobes.
REQ-018 After the strobe for index NUM_REGS-1, the block SHALL enter DONE.
REQ-019 busy SHALL be 1 in LOAD, RUN and DUMP, and 0 otherwise.
REQ-020 done SHALL be 1 in DONE only.
REQ-021 In DONE, start SHALL be handled as in IDLE (new session or err pulse); in LOAD, RUN and DUMP, start SHALL be ignored.
REQ-022 A start in IDLE coinciding with s_valid=1 SHALL accept no byte in that cycle.

Reset
REQ-023 While reset=0, the block SHALL force IDLE asynchronously and clear all counters.
REQ-024 While reset=0, the outputs SHALL be: cpu_reset=1; s_ready, mem_we, cpu_run, dump_valid, busy, done and err all 0; mem_addr, mem_wdata, dbg_addr, dump_idx and dump_data all 0.
REQ-025 Reset asserted in the middle of LOAD, RUN or DUMP SHALL abort the session with no further mem_we or dump_valid.
REQ-026 After reset deasserts, the block SHALL require a new start before any activity.

Verification
REQ-027 Load bytes F2 1E F4 14 06 50 18 50 with prog_len=8 and RUN_CYCLES=4 -> 8 mem_we at addresses 0–7, then cpu_run high for 4 clocks, then dump R1=30, R2=20, R3=50, R4=10 and done=1.
REQ-028 Same program with s_valid deasserted for 3 cycles after every byte -> identical memory image and dump; mem_we count is exactly 8.
REQ-029 start with prog_len=7, 0 or 2**ADDR_W+1 -> a single err pulse, state stays IDLE, s_ready=0 and no mem_we.
REQ-030 reset=0 after the 5th accepted byte -> all outputs at reset values immediately; a following start with prog_len=8 reloads from address 0.
REQ-031 start held high throughout LOAD and RUN -> no restart and no err; after DONE, start with prog_len=8 begins a new LOAD.
REQ-032 NUM_REGS=4 and REG_W=32 parameter build, with dbg_rdata = index*0x11111111 -> 4 dump strobes with the matching values, on consecutive cycles.
